flex_stp_word_sr: RTL and testbench

Parametrised serial-to-parallel shift register with word framing, for the I2C datapath and other serial front-ends. It shifts `serial_in` on each `shift_enable` and counts bits. When a word of `NUM_BITS` bits completes, it captures the word into a holding register behind a valid/ready handshake. The live shift register keeps collecting the next word while the held word waits. Overrun is flagged when a completed word cannot be delivered.

---
 rtl/flex_stp_word_sr_pkg.sv | 21 ++
 rtl/flex_stp_word_sr_counter.sv | 44 ++++
 rtl/flex_stp_word_sr.sv | 127 ++++++++++++
 tb/tb_flex_stp_word_sr.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_stp_word_sr_pkg.sv
// -----------------------------------------------------------------------------
// flex_stp_word_sr_pkg
//   Shared constants for the framed serial-to-parallel shift register.
//   Holds the default word width and shift direction that a front-end
//   (e.g. the I2C datapath) uses when it instantiates flex_stp_word_sr.
//   No ports; import with "import flex_stp_word_sr_pkg::*;".
// -----------------------------------------------------------------------------
package flex_stp_word_sr_pkg;

  // Default word width in bits. Legal range is >= 2.
  localparam int unsigned DEFAULT_NUM_BITS = 8;

  // Default shift direction: 1 = MSB first, 0 = LSB first.
  localparam bit DEFAULT_SHIFT_MSB = 1'b1;

  // Width of a counter that runs 0..num_bits-1.
  function automatic int unsigned count_width(input int unsigned num_bits);
    return (num_bits < 2) ? 1 : $clog2(num_bits);
  endfunction

endpackage : flex_stp_word_sr_pkg

// File: rtl/flex_stp_word_sr_counter.sv
// -----------------------------------------------------------------------------
// flex_stp_word_sr_counter
//   Enabled up-counter with a programmable rollover value. It counts
//   0..ROLLOVER_VAL and then wraps to 0. The rollover strobe is high in the
//   cycle whose enabled edge performs the wrap. This lets the parent treat it
//   as a "last bit of the word is being sampled now" strobe.
//
// Ports
//   clk            in   clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   clear          in   synchronous clear to 0 (overrides count_enable)
//   count_enable   in   advance the count this cycle
//   count_out      out  WIDTH  current count
//   rollover_flag  out  1      count_enable && count_out == ROLLOVER_VAL
// -----------------------------------------------------------------------------
module flex_stp_word_sr_counter #(
  parameter int unsigned     WIDTH        = 3,
  parameter logic [WIDTH-1:0] ROLLOVER_VAL = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  // The strobe is combinational from the enable. It feeds the parent's
  // registers only, so no top-level output gets an input-to-output path.
  assign rollover_flag = count_enable && (count_out == ROLLOVER_VAL);

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : count_out + WIDTH'(1);
    end
  end

endmodule : flex_stp_word_sr_counter

// File: rtl/flex_stp_word_sr.sv
// -----------------------------------------------------------------------------
// flex_stp_word_sr
//   Serial-to-parallel shift register with word framing. Each shift_enable
//   shifts serial_in into the live register and counts one bit. When
//   NUM_BITS bits have been collected, the completed word is captured into a
//   holding register behind a valid/ready handshake. The live register keeps
//   collecting the next word. If a word completes while the holding register
//   is still occupied and not being accepted, the word is dropped and the
//   sticky overrun flag is raised.
//
//   Priority at every edge: clear > shift/complete > handshake.
//
// Ports
//   clk           in   clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous abort: partial word, held word, overrun
//   shift_enable  in   shift one bit this cycle
//   serial_in     in   serial data bit
//   shift_reg     out  NUM_BITS  live shift contents
//   bit_count     out  CNT_W     bits in the current partial word
//   word_out      out  NUM_BITS  held completed word
//   word_valid    out  1         word_out is valid
//   word_ready    in   1         consumer accepts word_out
//   overrun       out  1         sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module flex_stp_word_sr
  import flex_stp_word_sr_pkg::*;
#(
  parameter int unsigned           NUM_BITS  = DEFAULT_NUM_BITS,
  parameter bit                    SHIFT_MSB = DEFAULT_SHIFT_MSB,
  parameter logic [NUM_BITS-1:0]   RESET_VAL = '1,
  localparam int unsigned          CNT_W     = count_width(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] shift_reg,
  output logic [CNT_W-1:0]    bit_count,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] next_word;     // shift_reg after this cycle's shift
  logic                word_done;     // final bit of a word shifts this edge
  logic                holding_free;  // holding register can take a word now
  logic                transfer;      // consumer takes word_out this edge

  // ---------------------------------------------------------------------------
  // Bit counter. The rollover strobe is the word-completion strobe.
  // ---------------------------------------------------------------------------
  flex_stp_word_sr_counter #(
    .WIDTH        (CNT_W),
    .ROLLOVER_VAL (LAST_BIT)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (shift_enable),
    .count_out     (bit_count),
    .rollover_flag (word_done)
  );

  // ---------------------------------------------------------------------------
  // Shift direction. MSB-first shifts left and inserts at bit 0. LSB-first
  // shifts right and inserts at the top, so the first bit received ends up
  // in bit 0.
  // ---------------------------------------------------------------------------
  if (SHIFT_MSB) begin : g_msb_first
    assign next_word = {shift_reg[NUM_BITS-2:0], serial_in};
  end else begin : g_lsb_first
    assign next_word = {serial_in, shift_reg[NUM_BITS-1:1]};
  end

  // The slot is free when it is empty or is being emptied this very edge.
  // That lets back-to-back words keep word_valid high with no bubble.
  assign holding_free = !word_valid || word_ready;
  assign transfer     = word_valid && word_ready;

  // ---------------------------------------------------------------------------
  // Live shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= RESET_VAL;
    end else if (clear) begin
      shift_reg <= RESET_VAL;
    end else if (shift_enable) begin
      // Not reloaded on completion; the next word simply shifts over it.
      shift_reg <= next_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register, handshake and overrun
  // ---------------------------------------------------------------------------
  // NOTE: word_out is a data register but still gets a reset value. The
  // interface defines its value after reset and after clear, and it is small.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (holding_free) begin
        word_out   <= next_word;
        word_valid <= 1'b1;
      end else begin
        // The held word is kept and the new one is lost.
        overrun <= 1'b1;
      end
    end else if (transfer) begin
      // word_out keeps its last value after the transfer.
      word_valid <= 1'b0;
    end
  end

endmodule : flex_stp_word_sr

// File: tb/tb_flex_stp_word_sr.sv
// -----------------------------------------------------------------------------
// tb_flex_stp_word_sr
//   Self-checking bench for flex_stp_word_sr. It drives one MSB-first and one
//   LSB-first instance (NUM_BITS=8) from shared stimulus. Expected words are
//   queued when their final bit is driven and compared when the word appears
//   on word_out. Inputs change on the falling edge; outputs are sampled 1 ns
//   after the rising edge.
// -----------------------------------------------------------------------------
module tb_flex_stp_word_sr;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       shift_enable;
  logic       serial_in;
  logic       word_ready;

  logic [7:0] m_shift_reg, m_word_out;
  logic [2:0] m_bit_count;
  logic       m_word_valid, m_overrun;

  logic [7:0] l_shift_reg, l_word_out;
  logic [2:0] l_bit_count;
  logic       l_word_valid, l_overrun;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  flex_stp_word_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .RESET_VAL(8'hFF)) dut_msb (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .shift_reg    (m_shift_reg),
    .bit_count    (m_bit_count),
    .word_out     (m_word_out),
    .word_valid   (m_word_valid),
    .word_ready   (word_ready),
    .overrun      (m_overrun)
  );

  flex_stp_word_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .RESET_VAL(8'hFF)) dut_lsb (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .shift_reg    (l_shift_reg),
    .bit_count    (l_bit_count),
    .word_out     (l_word_out),
    .word_valid   (l_word_valid),
    .word_ready   (word_ready),
    .overrun      (l_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------- stimulus
  task automatic send_bit(input logic b, input logic ready);
    @(negedge clk);
    shift_enable = 1'b1;
    serial_in    = b;
    word_ready   = ready;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    word_ready   = 1'b0;
  endtask

  // Eight consecutive shifts; word_ready is driven only with the final bit.
  task automatic send_word(input logic [7:0] w, input logic msb_first,
                           input logic ready_last);
    for (int i = 0; i < 8; i++)
      send_bit(msb_first ? w[7-i] : w[i], (i == 7) ? ready_last : 1'b0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0;
    serial_in = 1'b0; word_ready = 1'b0;
    #23;
    checks++; if (m_shift_reg !== 8'hFF) begin failures++; $display("FAIL reset_shift_reg_msb: got %h want ff", m_shift_reg); end
    checks++; if (l_shift_reg !== 8'hFF) begin failures++; $display("FAIL reset_shift_reg_lsb: got %h want ff", l_shift_reg); end
    checks++; if (m_bit_count !== 3'd0) begin failures++; $display("FAIL reset_bit_count: got %0d want 0", m_bit_count); end
    checks++; if (m_word_out !== 8'h00) begin failures++; $display("FAIL reset_word_out: got %h want 00", m_word_out); end
    checks++; if (m_word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid: got %b want 0", m_word_valid); end
    checks++; if (m_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", m_overrun); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_msb_first();
    send_word(8'hA5, 1'b1, 1'b0);
    exp_q.push_back(8'hA5);
    checks++; if (m_word_valid !== 1'b1) begin failures++; $display("FAIL msb_valid: got %b want 1", m_word_valid); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL msb_word: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word) begin failures++; $display("FAIL msb_word: got %h want %h", m_word_out, exp_word); end end
    checks++; if (m_bit_count !== 3'd0) begin failures++; $display("FAIL msb_bit_count: got %0d want 0", m_bit_count); end
    checks++; if (m_shift_reg !== 8'hA5) begin failures++; $display("FAIL msb_shift_reg: got %h want a5", m_shift_reg); end
    // Consume the word with no new completion: valid drops, data holds.
    @(negedge clk);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    checks++; if (m_word_valid !== 1'b0) begin failures++; $display("FAIL msb_accept_valid: got %b want 0", m_word_valid); end
    checks++; if (m_word_out !== 8'hA5) begin failures++; $display("FAIL msb_accept_hold: got %h want a5", m_word_out); end
    // Ready with nothing valid changes nothing.
    @(negedge clk);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    checks++; if (m_word_valid !== 1'b0 || m_overrun !== 1'b0) begin failures++; $display("FAIL idle_ready: got valid=%b overrun=%b want 0/0", m_word_valid, m_overrun); end
  endtask

  task automatic test_lsb_first();
    do_clear();
    checks++; if (l_shift_reg !== 8'hFF) begin failures++; $display("FAIL lsb_clear_shift_reg: got %h want ff", l_shift_reg); end
    send_word(8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    checks++; if (l_word_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid: got %b want 1", l_word_valid); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL lsb_word: got %h want <empty queue>", l_word_out); end
    else begin exp_word = exp_q.pop_front(); if (l_word_out !== exp_word) begin failures++; $display("FAIL lsb_word: got %h want %h", l_word_out, exp_word); end end
    checks++; if (l_shift_reg !== 8'h3C) begin failures++; $display("FAIL lsb_shift_reg: got %h want 3c", l_shift_reg); end
  endtask

  task automatic test_overrun();
    do_clear();
    send_word(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h11);
    send_word(8'h22, 1'b1, 1'b0);  // holding register busy: 0x22 is dropped
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL ovr_word: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word) begin failures++; $display("FAIL ovr_word: got %h want %h", m_word_out, exp_word); end end
    checks++; if (m_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", m_overrun); end
    checks++; if (m_word_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b want 1", m_word_valid); end
    checks++; if (m_shift_reg !== 8'h22) begin failures++; $display("FAIL ovr_shift_reg: got %h want 22", m_shift_reg); end
    // Sticky: accepting the held word leaves overrun set.
    @(negedge clk);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    checks++; if (m_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", m_overrun); end
    do_clear();
    checks++; if (m_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear_flag: got %b want 0", m_overrun); end
    checks++; if (m_word_valid !== 1'b0) begin failures++; $display("FAIL ovr_clear_valid: got %b want 0", m_word_valid); end
    checks++; if (m_bit_count !== 3'd0) begin failures++; $display("FAIL ovr_clear_count: got %0d want 0", m_bit_count); end
    checks++; if (m_word_out !== 8'h00) begin failures++; $display("FAIL ovr_clear_word: got %h want 00", m_word_out); end
  endtask

  task automatic test_back_to_back();
    logic valid_dropped;
    do_clear();
    send_word(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h11);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_first: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word) begin failures++; $display("FAIL b2b_first: got %h want %h", m_word_out, exp_word); end end
    // Second word directly follows; ready only with its final bit.
    valid_dropped = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(8'h22 >> (7 - i) & 8'h01 ? 1'b1 : 1'b0, (i == 7));
      if (m_word_valid !== 1'b1) valid_dropped = 1'b1;
    end
    exp_q.push_back(8'h22);
    checks++; if (valid_dropped !== 1'b0) begin failures++; $display("FAIL b2b_valid_gap: got dropped=%b want 0", valid_dropped); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_second: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word) begin failures++; $display("FAIL b2b_second: got %h want %h", m_word_out, exp_word); end end
    checks++; if (m_overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b want 0", m_overrun); end
  endtask

  task automatic test_clear_mid_word();
    do_clear();
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    checks++; if (m_bit_count !== 3'd5) begin failures++; $display("FAIL cmw_count5: got %0d want 5", m_bit_count); end
    // clear together with shift_enable: the shift is ignored.
    @(negedge clk);
    clear = 1'b1; shift_enable = 1'b1; serial_in = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0; shift_enable = 1'b0;
    checks++; if (m_bit_count !== 3'd0) begin failures++; $display("FAIL cmw_count: got %0d want 0", m_bit_count); end
    checks++; if (m_shift_reg !== 8'hFF) begin failures++; $display("FAIL cmw_shift_reg: got %h want ff", m_shift_reg); end
    send_word(8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL cmw_word: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word || m_word_valid !== 1'b1) begin failures++; $display("FAIL cmw_word: got %h/v%b want %h/v1", m_word_out, m_word_valid, exp_word); end end
  endtask

  task automatic test_async_reset();
    do_clear();
    send_word(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL ar_word: got %h want <empty queue>", m_word_out); end
    else begin exp_word = exp_q.pop_front(); if (m_word_out !== exp_word) begin failures++; $display("FAIL ar_word: got %h want %h", m_word_out, exp_word); end end
    send_word(8'h7E, 1'b1, 1'b0);  // raises overrun
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    // Assert reset between edges and look before any rising edge.
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (m_shift_reg !== 8'hFF) begin failures++; $display("FAIL ar_shift_reg: got %h want ff", m_shift_reg); end
    checks++; if (m_bit_count !== 3'd0) begin failures++; $display("FAIL ar_bit_count: got %0d want 0", m_bit_count); end
    checks++; if (m_word_out !== 8'h00) begin failures++; $display("FAIL ar_word_out: got %h want 00", m_word_out); end
    checks++; if (m_word_valid !== 1'b0) begin failures++; $display("FAIL ar_word_valid: got %b want 0", m_word_valid); end
    checks++; if (m_overrun !== 1'b0) begin failures++; $display("FAIL ar_overrun: got %b want 0", m_overrun); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_clear_mid_word();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_flex_stp_word_sr
